// File: rtl/tick_event_scheduler.sv
// Two-channel event scheduler sharing one timestamped valid/ready event port.
// ch0 requests as soon as it is triggered. ch1 runs a delay FSM and requests
// DELAY enabled cycles after its trigger. Simultaneous requests are arbitrated
// round-robin.
//
// state  | meaning
// S_IDLE | ch1 free, next enabled trig1 is accepted
// S_WAIT | ch1 delay down-counter running (advances only while en=1)
// S_PEND | ch1 event requesting the output register
module tick_event_scheduler #(
    parameter int TW    = 16,
    parameter int DELAY = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          trig0,
    input  logic          trig1,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic          evt_id,
    output logic [TW-1:0] evt_time,
    output logic          busy1,
    output logic [DW-1:0] drop_cnt0,
    output logic [DW-1:0] drop_cnt1
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PEND} ch1_state_t;

    ch1_state_t    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] stamp1_q, stamp1_d;
    logic [TW-1:0] time_q, time_d;
    logic          pend0_q, pend0_d;
    logic [TW-1:0] stamp0_q, stamp0_d;
    logic          valid_q, valid_d;
    logic          id_q, id_d;
    logic [TW-1:0] etime_q, etime_d;
    logic          rr_q, rr_d;
    logic [DW-1:0] drop0_q, drop0_d;
    logic [DW-1:0] drop1_q, drop1_d;

    logic pend1;
    logic load;
    logic gnt0;
    logic gnt1;

    // Arbitration: rr_q holds the last granted channel, a lone requester always wins.
    always_comb begin
        pend1 = (state_q == S_PEND);
        load  = (!valid_q || evt_ready) && (pend0_q || pend1);
        gnt1  = load && pend1 && (!pend0_q || !rr_q);
        gnt0  = load && pend0_q && !gnt1;
    end

    // Next-state for time base, ch0 pending slot, ch1 FSM, drop counters and output register.
    always_comb begin
        time_d   = time_q;
        pend0_d  = pend0_q;
        stamp0_d = stamp0_q;
        drop0_d  = drop0_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        stamp1_d = stamp1_q;
        drop1_d  = drop1_q;
        valid_d  = valid_q;
        id_d     = id_q;
        etime_d  = etime_q;
        rr_d     = rr_q;

        if (en) begin
            time_d = time_q + TW'(1);
        end

        // A grant frees the slot in the same edge, so a fresh trigger can refill it.
        if (gnt0) begin
            pend0_d = 1'b0;
        end
        if (en && trig0) begin
            if (!pend0_q || gnt0) begin
                pend0_d  = 1'b1;
                stamp0_d = time_q;
            end else if (drop0_q != {DW{1'b1}}) begin
                drop0_d = drop0_q + DW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (en && trig1) begin
                    state_d  = S_WAIT;
                    cnt_d    = 8'(DELAY);
                    stamp1_d = time_q + TW'(DELAY);
                end
            end
            S_WAIT: begin
                if (en) begin
                    if (cnt_q == 8'd1) begin
                        state_d = S_PEND;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_PEND: begin
                if (gnt1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Triggers arriving while ch1 is busy are lost, including on its grant edge.
        if (en && trig1 && (state_q != S_IDLE) && (drop1_q != {DW{1'b1}})) begin
            drop1_d = drop1_q + DW'(1);
        end

        if (load) begin
            valid_d = 1'b1;
            id_d    = gnt1;
            etime_d = gnt1 ? stamp1_q : stamp0_q;
            rr_d    = gnt1;
        end else if (evt_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q   <= '0;
            pend0_q  <= 1'b0;
            stamp0_q <= '0;
            drop0_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            stamp1_q <= '0;
            drop1_q  <= '0;
            valid_q  <= 1'b0;
            id_q     <= 1'b0;
            etime_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            time_q   <= time_d;
            pend0_q  <= pend0_d;
            stamp0_q <= stamp0_d;
            drop0_q  <= drop0_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stamp1_q <= stamp1_d;
            drop1_q  <= drop1_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            etime_q  <= etime_d;
            rr_q     <= rr_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign evt_time  = etime_q;
    assign busy1     = (state_q != S_IDLE);
    assign drop_cnt0 = drop0_q;
    assign drop_cnt1 = drop1_q;

endmodule
